// File: rtl/ccc_apb_reconfig_master.sv
// APB initiator that turns single register commands into CCC configuration accesses.
// Optional PLL relock wait after writes is built only when CCC_RELOCK_WAIT_EN is defined.
module ccc_apb_reconfig_master #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_BLANK   = 16
) (
    input  logic       PCLK,
    input  logic       PRESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_relock,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [5:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       BUSY,
    input  logic       LOCK,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        SETUP,
        ACCESS,
`ifdef CCC_RELOCK_WAIT_EN
        LOCK_WAIT,
`endif
        RESP
    } state_t;

    state_t state, state_next;
    logic   ready_en;
    logic   write_q;
    logic   accept;
    logic   in_lock_wait;
    logic   lock_m, lock_s, lock_s_d;

    // cmd_ready stays low until the first edge after reset release
    assign cmd_ready = ready_en && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign PWRITE    = PSEL && write_q;
    assign rsp_valid = (state == RESP);

`ifdef CCC_RELOCK_WAIT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(LOCK_BLANK);

    logic             relock_q;
    logic             err_q;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_ok, lock_to;

    assign in_lock_wait = (state == LOCK_WAIT);
    assign lock_ok      = (lock_cnt >= CNT_BLANK) && lock_s;
    assign lock_to      = (lock_cnt == CNT_MAX) && !lock_s;
    assign rsp_err      = err_q;

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            relock_q <= 1'b0;
            err_q    <= 1'b0;
            lock_cnt <= '0;
        end else begin
            if (accept) begin
                relock_q <= cmd_relock;
                err_q    <= 1'b0;
            end
            if (state == ACCESS)
                lock_cnt <= '0;
            else if (in_lock_wait && (lock_cnt != CNT_MAX))
                lock_cnt <= lock_cnt + 1'b1;
            // A valid lock takes priority over the timeout on the same cycle
            if (in_lock_wait && (lock_ok || lock_to))
                err_q <= !lock_ok;
        end
    end
`else
    logic unused_relock;

    assign unused_relock = cmd_relock;
    assign in_lock_wait  = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = BUSY ? WAIT_BUSY : SETUP;
            WAIT_BUSY: if (!BUSY) state_next = SETUP;
            SETUP:     state_next = ACCESS;
`ifdef CCC_RELOCK_WAIT_EN
            ACCESS:    state_next = (write_q && relock_q) ? LOCK_WAIT : RESP;
            LOCK_WAIT: if (lock_ok || lock_to) state_next = RESP;
`else
            ACCESS:    state_next = RESP;
`endif
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            write_q   <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (accept) begin
                write_q <= cmd_write;
                PADDR   <= cmd_addr;
                PWDATA  <= cmd_wdata;
            end
            if ((state == ACCESS) && !write_q)
                rsp_rdata <= PRDATA;
        end
    end

    // LOCK is asynchronous; only lock_s is used by the logic
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            lock_s_d  <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_m    <= LOCK;
            lock_s    <= lock_m;
            lock_s_d  <= lock_s;
            lock_lost <= lock_s_d && !lock_s && !in_lock_wait;
        end
    end

endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Self-checking bench for ccc_apb_reconfig_master: vector table, directed corner
// sequences and randomized commands against a cycle-offset reference model.
`timescale 1ns/1ps
module tb_ccc_apb_reconfig_master;

    localparam int TO    = 64;
    localparam int BLANK = 16;
`ifdef CCC_RELOCK_WAIT_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif
    // extra cycles a relock write costs when LOCK stays high: blank period plus exit
    localparam int RELOCK_EXTRA = RELOCK_EN ? (BLANK + 1) : 0;

    logic       PCLK, PRESET_N;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_relock;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       BUSY, LOCK, lock_lost;

    ccc_apb_reconfig_master #(.LOCK_TIMEOUT(TO), .LOCK_BLANK(BLANK)) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_relock(cmd_relock),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .BUSY(BUSY), .LOCK(LOCK), .lock_lost(lock_lost)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] model_rdata;

    typedef struct {
        bit         wr;
        logic [5:0] addr;
        logic [7:0] wdata;
        bit         rl;
        int         busy;
        logic [7:0] prdata;
        int         lat;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response cycle (relative to acceptance) and error flag from the protocol rules.
    // lock_rise < 0: LOCK constantly high; otherwise LOCK low from the ACCESS cycle
    // and high again lock_rise cycles later (two synchronizer cycles before it is seen).
    function automatic int model_resp(input int b, input bit wr, input bit rl,
                                      input int lock_rise, output bit err);
        int acc;
        int k_exit;
        acc = b + 2;
        err = 1'b0;
        if (!(RELOCK_EN && wr && rl)) return acc + 1;
        if (lock_rise < 0) k_exit = BLANK;
        else k_exit = (lock_rise + 1 > BLANK) ? lock_rise + 1 : BLANK;
        if (k_exit > TO) begin
            k_exit = TO;
            err    = 1'b1;
        end
        return acc + 2 + k_exit;
    endfunction

    task automatic run_txn(input string tag, input bit wr, input logic [5:0] addr,
                           input logic [7:0] wdata, input bit rl, input int b,
                           input logic [7:0] prdata, input int lock_rise,
                           input int exp_lat, input logic [7:0] exp_rdata, input bit exp_err);
        int acc;
        logic [5:0] exp_ctl;
        acc = b + 2;
        for (int i = 0; i <= exp_lat + 1; i++) begin
            @(negedge PCLK);
            exp_ctl[5] = (i == 0) || (i == exp_lat + 1);
            exp_ctl[4] = (i == b + 1) || (i == acc);
            exp_ctl[3] = (i == acc);
            exp_ctl[2] = wr && ((i == b + 1) || (i == acc));
            exp_ctl[1] = (i == exp_lat);
            exp_ctl[0] = 1'b0;
            check($sformatf("%s ctl c%0d rdy/psel/pen/pwr/rsp/lost", tag, i),
                  {26'd0, cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, lock_lost}, {26'd0, exp_ctl});
            if ((i == b + 1) || (i == acc) || (i == exp_lat + 1))
                check($sformatf("%s paddr/pwdata c%0d", tag, i), {PADDR, PWDATA}, {addr, wdata});
            if (i == exp_lat) begin
                check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
                check({tag, " rsp_err"}, rsp_err, exp_err);
            end
            if (i == exp_lat + 1)
                check({tag, " rsp_rdata hold"}, rsp_rdata, exp_rdata);

            if (i == 0) begin
                cmd_valid  = 1'b1;
                cmd_write  = wr;
                cmd_addr   = addr;
                cmd_wdata  = wdata;
                cmd_relock = rl;
            end else if (i < exp_lat) begin
                cmd_valid  = 1'b1;
                cmd_write  = 1'($urandom);
                cmd_addr   = 6'($urandom);
                cmd_wdata  = 8'($urandom);
                cmd_relock = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (i < b)       BUSY = 1'b1;
            else if (i == b) BUSY = 1'b0;
            else             BUSY = 1'($urandom);
            PRDATA = (i == acc) ? prdata : 8'($urandom);
            LOCK   = (lock_rise < 0) || (i < acc) || (i >= acc + lock_rise);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit         wr, rl, err;
        int         b, lat;
        logic [5:0] addr;
        logic [7:0] wdata, prd, exp_rd;

        vecs[0] = '{1'b1, 6'h2A, 8'h5C, 1'b0, 0, 8'hE1, 3, 8'h00};
        vecs[1] = '{1'b0, 6'h05, 8'h00, 1'b0, 0, 8'hA7, 3, 8'hA7};
        vecs[2] = '{1'b1, 6'h11, 8'h33, 1'b0, 5, 8'hC3, 8, 8'hA7};
        vecs[3] = '{1'b0, 6'h3F, 8'h12, 1'b0, 2, 8'h5A, 5, 8'h5A};
        vecs[4] = '{1'b1, 6'h00, 8'hFF, 1'b1, 0, 8'hC3, 3 + RELOCK_EXTRA, 8'h5A};
        vecs[5] = '{1'b0, 6'h20, 8'h00, 1'b0, 1, 8'h00, 4, 8'h00};
        vecs[6] = '{1'b0, 6'h01, 8'h00, 1'b1, 0, 8'h77, 3, 8'h77};
        vecs[7] = '{1'b1, 6'h3F, 8'h00, 1'b1, 3, 8'h3C, 6 + RELOCK_EXTRA, 8'h77};

        PRESET_N   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_relock = 1'b0;
        PRDATA     = '0;
        BUSY       = 1'b0;
        LOCK       = 1'b1;

        repeat (3) @(negedge PCLK);
        check("reset ctl", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, lock_lost}, 7'd0);
        check("reset paddr/pwdata/rdata", {PADDR, PWDATA, rsp_rdata}, 22'd0);
        PRESET_N = 1'b1;
        #1;
        check("cmd_ready before first edge", cmd_ready, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rl,
                    vecs[i].busy, vecs[i].prdata, -1, vecs[i].lat, vecs[i].rdata, 1'b0);
            model_rdata = vecs[i].rdata;
        end

        // LOCK falling in IDLE produces a single lock_lost pulse three cycles later
        @(negedge PCLK);
        LOCK = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge PCLK);
            check($sformatf("lock_lost idle c%0d", i), lock_lost, (i == 3));
        end
        LOCK = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge PCLK);
            check($sformatf("lock_lost on rise c%0d", i), lock_lost, 1'b0);
        end

`ifdef CCC_RELOCK_WAIT_EN
        lat = model_resp(0, 1'b1, 1'b1, 40, err);
        run_txn("relock_ok", 1'b1, 6'h12, 8'h34, 1'b1, 0, 8'h00, 40, lat, model_rdata, err);
        lat = model_resp(0, 1'b1, 1'b1, 1000, err);
        run_txn("relock_timeout", 1'b1, 6'h13, 8'h35, 1'b1, 0, 8'h00, 1000, lat, model_rdata, err);
        LOCK = 1'b1;
        repeat (3) @(negedge PCLK);
        lat = model_resp(1, 1'b1, 1'b1, TO - 1, err);
        run_txn("relock_at_limit", 1'b1, 6'h14, 8'h36, 1'b1, 1, 8'h00, TO - 1, lat, model_rdata, err);
        lat = model_resp(0, 1'b1, 1'b1, TO, err);
        run_txn("relock_one_late", 1'b1, 6'h15, 8'h37, 1'b1, 0, 8'h00, TO, lat, model_rdata, err);
        LOCK = 1'b1;
        repeat (3) @(negedge PCLK);
`endif

        // Reset pulse during ACCESS of a read abandons the command
        @(negedge PCLK);
        check("rst seq idle ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 6'h05;
        BUSY      = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("rst seq setup", {PSEL, PENABLE}, 2'b10);
        @(negedge PCLK);
        check("rst seq access", {PSEL, PENABLE}, 2'b11);
        PRDATA   = 8'h99;
        PRESET_N = 1'b0;
        #1;
        check("rst seq async clear", {PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid}, 5'd0);
        check("rst seq regs", {PADDR, rsp_rdata}, 14'd0);
        #2;
        PRESET_N = 1'b1;
        @(negedge PCLK);
        check("rst seq ready after release", {cmd_ready, rsp_valid, PSEL}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check($sformatf("rst seq no rsp c%0d", i), {rsp_valid, PSEL}, 2'b00);
        end
        model_rdata = 8'h00;

        for (int t = 0; t < 40; t++) begin
            wr    = 1'($urandom);
            rl    = 1'($urandom);
            b     = $urandom_range(0, 4);
            addr  = 6'($urandom);
            wdata = 8'($urandom);
            prd   = 8'($urandom);
            lat   = model_resp(b, wr, rl, -1, err);
            exp_rd = wr ? model_rdata : prd;
            run_txn($sformatf("rand%0d", t), wr, addr, wdata, rl, b, prd, -1, lat, exp_rd, err);
            model_rdata = exp_rd;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
